// File: rtl/stepper_phase_decoder_if.sv
// stepper_phase_decoder_if: coil lines and clear toward the decoder, decoded motion back out.
interface stepper_phase_decoder_if #(
  parameter int POS_W    = 16,
  parameter int PERIOD_W = 20
);
  logic                in1;
  logic                in2;
  logic                in3;
  logic                in4;
  logic                clr;
  logic                step_pulse;
  logic                dir;
  logic [POS_W-1:0]    position;
  logic [1:0]          phase;
  logic                energized;
  logic                moving;
  logic                fault;
  logic [7:0]          skip_cnt;
  logic [PERIOD_W-1:0] period;
  logic                period_valid;
  modport master (
    output in1, in2, in3, in4, clr,
    input  step_pulse, dir, position, phase, energized, moving, fault, skip_cnt, period, period_valid
  );
  modport slave (
    input  in1, in2, in3, in4, clr,
    output step_pulse, dir, position, phase, energized, moving, fault, skip_cnt, period, period_valid
  );
endinterface

// File: rtl/stepper_phase_decoder.sv
// stepper_phase_decoder: rebuilds step/dir/position from wave-drive coil lines.
// Optional step-period measurement enabled by STEPPER_DECODER_PERIOD_EN.
module stepper_phase_decoder #(
  parameter int FILTER_CYCLES = 4,
  parameter int POS_W         = 16,
  parameter int IDLE_CYCLES   = 270000,
  parameter int PERIOD_W      = 20
) (
  input logic clk,
  input logic rst,
  stepper_phase_decoder_if.slave bus
);
  localparam int CW = $clog2(FILTER_CYCLES + 2);
  localparam logic [CW-1:0] FC = CW'(FILTER_CYCLES);
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam logic [IW-1:0] IC = IW'(IDLE_CYCLES);
  typedef enum logic [1:0] {S_OFF, S_TRACK, S_FAULT} state_t;
  state_t st_q, st_d;
  logic [3:0] s1_q, s2_q, last_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic acc, zero, multi;
  logic [1:0] q, phase_q, phase_d;
  logic step_q, step_d, dir_q, dir_d, en_q, en_d, fault_q, fault_d, moving_q, moving_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [7:0] skip_q, skip_d;
  logic [IW-1:0] idle_q, idle_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      last_q <= '0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= {bus.in4, bus.in3, bus.in2, bus.in1};
      s2_q   <= s1_q;
      last_q <= s2_q;
      cnt_q  <= cnt_d;
    end
  // counter saturates one past FC so a held pattern is accepted exactly once
  always_comb begin
    cnt_d = (s2_q != last_q) ? CW'(1) : (cnt_q == FC + CW'(1)) ? cnt_q : cnt_q + CW'(1);
    acc   = cnt_q == FC;
    zero  = last_q == 4'b0000;
    multi = !zero && !$onehot(last_q);
    q     = last_q[1] ? 2'd1 : last_q[2] ? 2'd2 : last_q[3] ? 2'd3 : 2'd0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) st_q <= S_OFF;
    else     st_q <= st_d;
  always_comb
    st_d = bus.clr ? S_OFF : !acc ? st_q : (st_q == S_FAULT || multi) ? S_FAULT : zero ? S_OFF : S_TRACK;
  always_comb begin
    step_d  = 1'b0;
    dir_d   = dir_q;
    pos_d   = pos_q;
    phase_d = phase_q;
    en_d    = en_q;
    fault_d = fault_q;
    skip_d  = skip_q;
    if (bus.clr) begin
      pos_d   = '0;
      skip_d  = '0;
      fault_d = 1'b0;
      en_d    = 1'b0;
    end else if (acc && st_q != S_FAULT) begin
      if (multi) begin
        fault_d = 1'b1;
        en_d    = 1'b0;
      end else if (zero) begin
        en_d = 1'b0;
      end else if (st_q == S_OFF) begin
        phase_d = q;
        en_d    = 1'b1;
      end else if (q == phase_q + 2'd1) begin
        step_d  = 1'b1;
        dir_d   = 1'b1;
        pos_d   = pos_q + POS_W'(1);
        phase_d = q;
      end else if (q == phase_q - 2'd1) begin
        step_d  = 1'b1;
        dir_d   = 1'b0;
        pos_d   = pos_q - POS_W'(1);
        phase_d = q;
      end else if (q == phase_q + 2'd2) begin
        skip_d  = (skip_q == 8'hFF) ? skip_q : skip_q + 8'd1;
        phase_d = q;
      end
    end
    idle_d   = step_d ? '0 : (idle_q == IC) ? idle_q : idle_q + IW'(1);
    moving_d = step_d | (moving_q & (idle_d != IC));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      pos_q    <= '0;
      phase_q  <= '0;
      en_q     <= 1'b0;
      fault_q  <= 1'b0;
      skip_q   <= '0;
      idle_q   <= '0;
      moving_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      dir_q    <= dir_d;
      pos_q    <= pos_d;
      phase_q  <= phase_d;
      en_q     <= en_d;
      fault_q  <= fault_d;
      skip_q   <= skip_d;
      idle_q   <= idle_d;
      moving_q <= moving_d;
    end
  assign bus.step_pulse = step_q;
  assign bus.dir        = dir_q;
  assign bus.position   = pos_q;
  assign bus.phase      = phase_q;
  assign bus.energized  = en_q;
  assign bus.fault      = fault_q;
  assign bus.skip_cnt   = skip_q;
  assign bus.moving     = moving_q;
`ifdef STEPPER_DECODER_PERIOD_EN
  logic [PERIOD_W-1:0] pcnt_q, pcnt_d, pinc, per_q, per_d;
  logic arm_q, arm_d, pv_q, pv_d;
  // latch the incremented count so spacing of N clocks reads back as N
  always_comb begin
    pinc   = &pcnt_q ? pcnt_q : pcnt_q + PERIOD_W'(1);
    pcnt_d = step_d ? '0 : pinc;
    per_d  = bus.clr ? '0 : step_d ? pinc : per_q;
    arm_d  = (bus.clr || st_q == S_OFF) ? 1'b0 : step_d ? 1'b1 : arm_q;
    pv_d   = (bus.clr || st_q == S_OFF) ? 1'b0 : step_d ? arm_q : pv_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pcnt_q <= '0;
      per_q  <= '0;
      arm_q  <= 1'b0;
      pv_q   <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      per_q  <= per_d;
      arm_q  <= arm_d;
      pv_q   <= pv_d;
    end
  assign bus.period       = per_q;
  assign bus.period_valid = pv_q;
`else
  assign bus.period       = {PERIOD_W{1'b0}};
  assign bus.period_valid = 1'b0;
`endif
endmodule

// File: doc/stepper_phase_decoder.md
# stepper_phase_decoder

Monitors the four wave-drive coil lines of a unipolar stepper (in1..in4, one coil energised at a time) and reconstructs the motion the controller commanded. It outputs step pulses, direction, a signed position count, motion status, pattern faults and, optionally, step period. It sits on the receive side of the coil interface, either on the coil pins for closed-loop checking or on a second board listening to the same lines.

## Interface
Parameters:
- FILTER_CYCLES, 4 — clocks a synchronised pattern must hold unchanged before it is accepted (≥1)
- POS_W, 16 — position counter width
- IDLE_CYCLES, 270000 — clocks without an accepted step before `moving` drops (10 ms at 27 MHz)
- PERIOD_W, 20 — step-period counter width

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous and active-high
- in1, in2, in3, in4  in  1 each  coil lines, asynchronous; pattern = {in4,in3,in2,in1}
- clr  in  1  synchronous clear of position, fault, skip count and period
- step_pulse  out  1  one-cycle pulse per accepted adjacent step
- dir  out  1  direction of last step; 1 = in1→in2→in3→in4, 0 = reverse
- position  out  POS_W  signed step count
- phase  out  2  index of current energised coil (in1 = 0 … in4 = 3)
- energized  out  1  accepted pattern is a legal single coil
- moving  out  1  step seen within last IDLE_CYCLES
- fault  out  1  sticky; multi-coil pattern accepted
- skip_cnt  out  8  saturating count of ±2 phase jumps
- period  out  PERIOD_W  clocks between the last two steps
- period_valid  out  1  period holds a real measurement

## Operation
- Front end: 2-flop synchroniser on each line, then stability filter. Filter counter resets on any change of the synchronised pattern. The pattern is accepted when it has held for FILTER_CYCLES clocks; each stable pattern is accepted once.
- States: OFF, TRACK, FAULT. Reset state is OFF.
- OFF: an accepted one-hot pattern q sets phase=q, energized=1 and moves to TRACK. No step is produced. An accepted multi-bit pattern moves to FAULT.
- TRACK, accepted pattern relative to current phase p:
  - q=p+1 mod 4: step_pulse, dir=1, position+1.
  - q=p−1 mod 4: step_pulse, dir=0, position−1.
  - q=p+2 mod 4: no step, position unchanged, skip_cnt+1 (saturates at 255), phase=q, dir unchanged.
  - all-zero: go to OFF, energized=0, phase and position retained.
  - multi-bit: go to FAULT.
- FAULT: fault=1, energized=0, position and phase frozen, no steps. Exits only on clr (to OFF) or rst.
- Position wraps modulo 2^POS_W in two's complement, with no saturation.
- `moving`: set on each step_pulse. The idle counter clears on each step and saturates; `moving` clears when the counter reaches IDLE_CYCLES.
- Simultaneous events: clr wins over an acceptance in the same cycle. clr zeroes position, skip_cnt, fault, period and period_valid, and suppresses step_pulse. Phase, energized and the state are then taken from the current accepted pattern on the next acceptance.
- Repeated identical patterns, such as a driver dwell, produce no steps.

## Timing
- Reset values: step_pulse, dir, position, phase, energized, moving, fault, skip_cnt, period, period_valid are all 0.
- Latency: from the first clk edge that samples a new stable coil pattern to step_pulse high is FILTER_CYCLES+2 clocks.
- Glitches shorter than FILTER_CYCLES clocks (after sync) are never accepted.
- position, dir and phase update in the same cycle as step_pulse.
- Two steps can be no closer than FILTER_CYCLES clocks apart.

## Configuration
- Macro STEPPER_DECODER_PERIOD_EN.
- Defined:
  - A free-running PERIOD_W counter, saturating at all-ones, clears on each step.
  - On each step, period latches the counter value.
  - period_valid asserts on the second step after rst, clr or OFF entry.
- Undefined: no period logic is built; period and period_valid are tied 0.

## Test plan
- After reset, drive 0001,0010,0100,1000,0001, each held 50 clocks → 4 pulses, dir=1, position=4, phase=0.
- From 0001, drive 1000,0100 → 2 pulses, dir=0, position=−2.
- From 0001, drive 0100 → no pulse, skip_cnt=1, phase=2. Then drive 1000 → pulse, position+1.
- Drive 0011 for 50 clocks → fault=1. Further one-hot steps leave position frozen. Pulse clr → fault=0, position=0, state OFF.
- With FILTER_CYCLES=4, apply a 3-clock glitch 0001→0010→0001 → no pulse. Held step → pulse exactly 6 clocks after the first sampling edge.
- With STEPPER_DECODER_PERIOD_EN and steps 1000 clocks apart → period_valid after the 2nd step, period=1000. Stop stepping → moving=0 IDLE_CYCLES clocks after the last step.
